// File: rtl/sapho_pc_pkg.sv
// Shared types and constants for the sapho program-counter sequencer.
package sapho_pc_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_RET = 1'b1
    } state_e;

    // Request kinds, higher encoding wins when several are raised together
    typedef enum logic [2:0] {
        REQ_NONE = 3'd0,
        REQ_JZ   = 3'd1,
        REQ_JMP  = 3'd2,
        REQ_CALL = 3'd3,
        REQ_RET  = 3'd4
    } req_e;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned NCNT      = $clog2(DEPTH_DEF + 1);

    function automatic req_e sel_req(input logic ret, input logic call,
                                     input logic jmp, input logic jz);
        req_e r;
        r = REQ_NONE;
        if (ret)       r = REQ_RET;
        else if (call) r = REQ_CALL;
        else if (jmp)  r = REQ_JMP;
        else if (jz)   r = REQ_JZ;
        return r;
    endfunction

endpackage

// File: rtl/pc_stack_ctrl_depth_cnt.sv
// Up/down occupancy counter for the subroutine stack with full/empty flags.
module stk_depth_cnt
    import sapho_pc_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full)      cnt_d = cnt_q + CNT_W'(1);
        else if (dec && !inc && !empty) cnt_d = cnt_q - CNT_W'(1);
    end

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_stack_ctrl.sv
// Program-counter sequencer: CALL/RET/JMP/JZ resolution and stack initiator.
// Stack depth checking and the err flag are enabled by SAPHO_STACK_CHK_EN.
module pc_stack_ctrl
    import sapho_pc_pkg::*;
#(
    parameter int unsigned NADDR = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             call,
    input  logic             ret,
    input  logic             jmp,
    input  logic             jz,
    input  logic             zf,
    input  logic [NADDR-1:0] addr,
    output logic [NADDR-1:0] pc,
    output logic             fetch_vld,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [NADDR-1:0] stk_din,
    input  logic [NADDR-1:0] stk_dout,
    output logic             err
);

    state_e           state_q, state_d;
    logic [NADDR-1:0] pc_q, pc_d, pc_inc_c;
    logic             err_q, err_d;
    logic             push_c, pop_c;
    logic             full_c, empty_c;
    req_e             req_c;

`ifdef SAPHO_STACK_CHK_EN
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    stk_depth_cnt #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_depth (
        .clk   (clk),
        .rst   (rst),
        .inc   (stk_push),
        .dec   (stk_pop),
        .full  (full_c),
        .empty (empty_c)
    );
`else
    assign full_c  = 1'b0;
    assign empty_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign pc_inc_c = pc_q + NADDR'(1);
    assign req_c    = sel_req(ret, call, jmp, jz);

    // Next-state and strobe decode; an over/underflowing request degrades to an increment
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        if (en) begin
            unique case (state_q)
                S_RUN: begin
                    unique case (req_c)
                        REQ_RET: begin
                            if (empty_c) begin
                                pc_d  = pc_inc_c;
                                err_d = 1'b1;
                            end else begin
                                state_d = S_RET;
                            end
                        end
                        REQ_CALL: begin
                            if (full_c) begin
                                pc_d  = pc_inc_c;
                                err_d = 1'b1;
                            end else begin
                                push_c = 1'b1;
                                pc_d   = addr;
                            end
                        end
                        REQ_JMP:  pc_d = addr;
                        REQ_JZ:   pc_d = zf ? addr : pc_inc_c;
                        default:  pc_d = pc_inc_c;
                    endcase
                end
                S_RET: begin
                    pop_c   = 1'b1;
                    pc_d    = stk_dout;
                    state_d = S_RUN;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    assign pc        = pc_q;
    assign fetch_vld = rst & (state_q == S_RUN);
    assign stk_push  = rst & push_c;
    assign stk_pop   = rst & pop_c;
    assign stk_din   = pc_inc_c;
    assign err       = err_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed plus randomized bench for pc_stack_ctrl with an attached stack model.
module tb_pc_stack_ctrl;

    localparam int NADDR = 10;
    localparam int AMOD  = 1 << NADDR;
`ifdef SAPHO_STACK_CHK_EN
    localparam int DEPTH = 2;
    localparam bit CHK   = 1'b1;
`else
    localparam int DEPTH = 8;
    localparam bit CHK   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0, call = 1'b0, ret = 1'b0, jmp = 1'b0, jz = 1'b0, zf = 1'b0;
    logic [NADDR-1:0] addr = '0;
    logic [NADDR-1:0] pc, stk_din;
    logic [NADDR-1:0] stk_dout = '0;
    logic             fetch_vld, stk_push, stk_pop, err;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int m_pc  = 0;
    bit m_bub = 1'b0;
    bit m_err = 1'b0;
    int m_dep = 0;
    int m_stk[$];

    // Environment stack driven by the DUT strobes, registered top-of-stack
    logic [NADDR-1:0] env_stk[$];

    pc_stack_ctrl #(.NADDR(NADDR), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .call      (call),
        .ret       (ret),
        .jmp       (jmp),
        .jz        (jz),
        .zf        (zf),
        .addr      (addr),
        .pc        (pc),
        .fetch_vld (fetch_vld),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stk_push === 1'b1) env_stk.push_back(stk_din);
        else if (stk_pop === 1'b1 && env_stk.size() > 0) void'(env_stk.pop_back());
        if (env_stk.size() > 0) stk_dout <= env_stk[$];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check mid-cycle, then advance the model at the edge
    task automatic step(input bit r, input bit e, input bit c, input bit rt,
                        input bit j, input bit z, input bit zfl, input int a);
        bit e_push, e_pop, n_bub, n_er;
        int n_pc, n_dep, inc;
        rst = r; en = e; call = c; ret = rt; jmp = j; jz = z; zf = zfl;
        addr = NADDR'(a);
        @(negedge clk);
        e_push = 1'b0; e_pop = 1'b0;
        n_bub = m_bub; n_er = m_err; n_pc = m_pc; n_dep = m_dep;
        inc = (m_pc + 1) % AMOD;
        if (!r) begin
            n_pc = 0; n_bub = 1'b0; n_er = 1'b0; n_dep = 0;
        end else if (!e) begin
            n_pc = m_pc;
        end else if (m_bub) begin
            e_pop = 1'b1; n_bub = 1'b0; n_dep = m_dep - 1;
        end else if (rt) begin
            if (CHK && m_dep == 0) begin n_pc = inc; n_er = 1'b1; end
            else n_bub = 1'b1;
        end else if (c) begin
            if (CHK && m_dep == DEPTH) begin n_pc = inc; n_er = 1'b1; end
            else begin e_push = 1'b1; n_pc = a; n_dep = m_dep + 1; end
        end else if (j) begin
            n_pc = a;
        end else if (z && zfl) begin
            n_pc = a;
        end else begin
            n_pc = inc;
        end
        check("pc", 32'(pc), 32'(m_pc));
        check("fetch_vld", 32'(fetch_vld), 32'(r && !m_bub));
        check("stk_push", 32'(stk_push), 32'(e_push));
        check("stk_pop", 32'(stk_pop), 32'(e_pop));
        check("stk_din", 32'(stk_din), 32'(inc));
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        if (e_push) m_stk.push_back(inc);
        if (e_pop && m_stk.size() > 0) n_pc = m_stk.pop_back();
        m_pc = n_pc; m_bub = n_bub; m_err = n_er; m_dep = n_dep;
        #1;
    endtask

    initial begin
        // Unchecked settle cycles so registered outputs leave X
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then free-running increment
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("inc_pc4", 32'(pc), 32'd4);

        // CALL/RET round trip from pc=5 to 0x40 and back to 6
        step(1, 1, 0, 0, 1, 0, 0, 5);
        step(1, 1, 1, 0, 0, 0, 0, 'h40);
        check("call_tgt", 32'(pc), 32'h40);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        check("ret_bubble", 32'(fetch_vld), 32'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("ret_pc", 32'(pc), 32'd6);

        // Back-to-back CALL then RET
        step(1, 1, 0, 0, 1, 0, 0, 3);
        step(1, 1, 1, 0, 0, 0, 0, 'h10);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("b2b_pc", 32'(pc), 32'd4);

        // Priority: call beats jmp; jz both ways
        step(1, 1, 0, 0, 1, 0, 0, 7);
        step(1, 1, 1, 0, 1, 0, 0, 'h20);
        check("prio_pc", 32'(pc), 32'h20);
        step(1, 1, 0, 0, 1, 0, 0, 9);
        step(1, 1, 0, 0, 0, 1, 0, 'h30);
        check("jz_nt", 32'(pc), 32'd10);
        step(1, 1, 0, 0, 0, 1, 1, 'h30);
        check("jz_t", 32'(pc), 32'h30);

        // Stall three cycles in the return bubble
        step(1, 1, 0, 1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 1, 1, 1, 0, 0, 'h77);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("stall_ret", 32'(pc), 32'd8);

        // Wrap: CALL at the top address pushes 0
        step(1, 1, 0, 0, 1, 0, 0, 'h3FF);
        check("wrap_din", 32'(stk_din), 32'd0);
        step(1, 1, 1, 0, 0, 0, 0, 'h55);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("wrap_ret", 32'(pc), 32'd0);

`ifdef SAPHO_STACK_CHK_EN
        // Overflow on the third nested call, then underflow after reset
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 'h100);
        step(1, 1, 1, 0, 0, 0, 0, 'h200);
        step(1, 1, 1, 0, 0, 0, 0, 'h300);
        check("ovf_pc", 32'(pc), 32'h201);
        check("ovf_err", 32'(err), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("rst_err", 32'(err), 32'd0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        check("unf_pc", 32'(pc), 32'd1);
        check("unf_err", 32'(err), 32'd1);
        check("unf_fv", 32'(fetch_vld), 32'd1);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bit r, e, c, rt, j, z, zfl;
            r   = ($urandom_range(0, 39) != 0);
            e   = ($urandom_range(0, 5) != 0);
            c   = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 4) == 0);
            j   = ($urandom_range(0, 5) == 0);
            z   = ($urandom_range(0, 3) == 0);
            zfl = ($urandom_range(0, 1) == 1);
            if (!CHK && m_stk.size() == 0) rt = 1'b0;
            step(r, e, c, rt, j, z, zfl, int'($urandom_range(0, AMOD - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
